// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with a persistent carry flag,
// saturating shifts and an iterative shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             branch,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             cout,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               sgn, hi;

    logic               accept, is_add, is_addc, is_mul, big;
    logic [SW-1:0]      sh;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sra, alu_res, a_mag, b_mag, mul_res;
    logic               alu_ovf, alu_ill;
    logic [WIDTH:0]     acc_hi;
    logic [2*WIDTH-1:0] prod;

    assign in_ready = state == IDLE || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign is_add   = op == 4'b0000;
    assign is_addc  = op == 4'b1000;
    assign is_mul   = op == 4'b1001 || op == 4'b1010;

    // Shift amounts at or beyond WIDTH saturate instead of wrapping.
    assign big = b >= WIDTH'(WIDTH);
    assign sh  = b[SW-1:0];
    assign sra = $signed(a) >>> sh;
    assign sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(is_addc && cout);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            4'b0000: begin
                alu_res = branch ? b : sum[WIDTH-1:0];
                alu_ovf = !branch && a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
            end
            4'b0001:          alu_res = -b;
            4'b0010:          alu_res = a & b;
            4'b0011:          alu_res = a ^ b;
            4'b0100, 4'b0110: alu_res = big ? {WIDTH{a[WIDTH-1]}} : sra;
            4'b0101:          alu_res = big ? '0 : a << sh;
            4'b0111:          alu_res = big ? '0 : a >> sh;
            4'b1000: begin
                alu_res = sum[WIDTH-1:0];
                alu_ovf = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
            end
            default:          alu_ill = !is_mul;
        endcase
    end

    // Multiply on magnitudes; the sign is restored once after the last step.
    assign a_mag   = a[WIDTH-1] ? -a : a;
    assign b_mag   = b[WIDTH-1] ? -b : b;
    assign acc_hi  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    assign prod    = sgn ? -acc : acc;
    assign mul_res = hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            cout      <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            hi        <= 1'b0;
        end else if (accept) begin
            if ((is_add && !branch) || is_addc)
                cout <= sum[WIDTH];
            if (is_mul) begin
                state     <= BUSY;
                out_valid <= 1'b0;
                mcand     <= a_mag;
                mplier    <= b_mag;
                acc       <= '0;
                cnt       <= CW'(WIDTH);
                sgn       <= a[WIDTH-1] ^ b[WIDTH-1];
                hi        <= op[1];
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= alu_res == '0;
                neg       <= alu_res[WIDTH-1];
                ovf       <= alu_ovf;
                illegal   <= alu_ill;
            end
        end else if (state == BUSY) begin
            if (cnt == '0) begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= mul_res;
                zero      <= mul_res == '0;
                neg       <= mul_res[WIDTH-1];
                ovf       <= 1'b0;
                illegal   <= 1'b0;
            end else begin
                acc    <= {acc_hi, acc[WIDTH-1:1]};
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an
// arithmetic reference model with an in-order result scoreboard.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, branch, out_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] a, b, result;
    logic        zero, neg, ovf, cout, illegal;

    typedef struct packed {
        logic [31:0] res;
        logic        z, n, o, ill, c;
    } exp_t;

    exp_t        sbq[$];
    logic        m_cout;
    logic        prev_v, prev_r;
    logic [31:0] prev_res;
    int          n_vec = 0;
    int          n_bad = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .branch(branch), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .neg(neg), .ovf(ovf), .cout(cout), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic br, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx  = longint'($signed(x));
        longint sy  = longint'($signed(y));
        longint ux  = 64'(x);
        longint uy  = 64'(y);
        longint cin = (o == 4'd8 && m_cout) ? 64'sd1 : 64'sd0;
        int     amt = (y >= 32) ? 63 : int'(y);
        longint r   = 64'sd0;
        longint t;
        e = '0;
        case (o)
            4'd0, 4'd8: begin
                if (o == 4'd0 && br) r = uy;
                else begin
                    r = ux + uy + cin;
                    t = sx + sy + cin;
                    e.o = t != longint'(int'(t));
                    m_cout = r[32];
                end
            end
            4'd1:       r = -sy;
            4'd2:       r = ux & uy;
            4'd3:       r = ux ^ uy;
            4'd4, 4'd6: r = sx >>> amt;
            4'd5:       r = ux << amt;
            4'd7:       r = ux >> amt;
            4'd9:       r = sx * sy;
            4'd10: begin
                r = sx * sy;
                r = r >>> 32;
            end
            default:    e.ill = 1'b1;
        endcase
        e.res = r[31:0];
        e.z   = e.res == 0;
        e.n   = e.res[31];
        e.c   = m_cout;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: record accepted ops, compare results as they are consumed.
    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            m_cout = 1'b0;
            prev_v = 1'b0;
        end else begin
            exp_t e;
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_result", result, prev_res);
            end
            if (out_valid && !out_ready) check("bp_in_ready", 32'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) check("spurious_result", 32'(out_valid), 0);
                else begin
                    e = sbq.pop_front();
                    check("result", result, e.res);
                    check("zero", 32'(zero), 32'(e.z));
                    check("neg", 32'(neg), 32'(e.n));
                    check("ovf", 32'(ovf), 32'(e.o));
                    check("illegal", 32'(illegal), 32'(e.ill));
                    check("cout", 32'(cout), 32'(e.c));
                end
            end
            if (in_valid && in_ready) sbq.push_back(model(op, branch, a, b));
            prev_v   = out_valid;
            prev_r   = out_ready;
            prev_res = result;
        end
    end

    task automatic send(input logic [3:0] o, input logic br, input logic [31:0] x, input logic [31:0] y);
        bit ok = 1'b0;
        op = o; branch = br; a = x; b = y; in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) check("accept_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for a multiply result while scrambling inputs that must be ignored.
    task automatic wait_valid(output int k);
        k = 0;
        while (k < 60) begin
            @(posedge clk);
            #1 k++;
            if (out_valid) break;
            check("busy_in_ready", 32'(in_ready), 0);
            in_valid = k < 20;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int k, seen;
        longint tp;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; branch = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_zero", 32'(zero), 0);
        check("rst_neg", 32'(neg), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_illegal", 32'(illegal), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst_in_ready", 32'(in_ready), 1);

        send(4'd0, 1'b0, 32'hFFFFFFFF, 32'h1);
        check("add_valid", 32'(out_valid), 1);
        check("add_result", result, 0);
        check("add_zero", 32'(zero), 1);
        check("add_cout", 32'(cout), 1);
        check("add_ovf", 32'(ovf), 0);
        send(4'd8, 1'b0, 32'h0, 32'h0);
        check("addc_result", result, 1);
        check("addc_cout", 32'(cout), 0);
        send(4'd0, 1'b0, 32'h7FFFFFFF, 32'h1);
        check("ovf_result", result, 32'h80000000);
        check("ovf_neg", 32'(neg), 1);
        check("ovf_flag", 32'(ovf), 1);
        send(4'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        send(4'd0, 1'b1, 32'hFFFFFFFF, 32'h1234);
        check("branch_result", result, 32'h1234);
        check("branch_cout", 32'(cout), 1);

        send(4'd5, 1'b0, 32'h80000001, 32'd4);
        check("sll4", result, 32'h00000010);
        send(4'd4, 1'b0, 32'h80000001, 32'd4);
        check("sra4", result, 32'hF8000000);
        send(4'd7, 1'b0, 32'h80000001, 32'd40);
        check("srl40", result, 32'h0);
        send(4'd6, 1'b0, 32'h80000001, 32'd40);
        check("sra40", result, 32'hFFFFFFFF);

        send(4'd9, 1'b0, 32'hFFFFFFFD, 32'd7);
        check("mul_busy_valid", 32'(out_valid), 0);
        wait_valid(k);
        check("mul_latency", 32'(k), 33);
        check("mul_result", result, 32'hFFFFFFEB);
        send(4'd10, 1'b0, 32'h80000000, 32'd2);
        wait_valid(k);
        check("mulh_latency", 32'(k), 33);
        check("mulh_result", result, 32'hFFFFFFFF);

        send(4'd3, 1'b0, 32'h12345678, 32'hFFFF0000);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 32'h5; b = 32'h6;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_result", result, 32'hEDCB5678);
            check("bp_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        send(4'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0);
        check("b2b_and", result, 32'h00F000F0);
        tp = longint'($time);
        send(4'd1, 1'b0, 32'h0, 32'd5);
        check("b2b_neg", result, 32'hFFFFFFFB);
        check("b2b_gap1", 32'(longint'($time) - tp), 10);
        tp = longint'($time);
        send(4'd3, 1'b0, 32'hAAAA5555, 32'hFFFF0000);
        check("b2b_xor", result, 32'h55555555);
        check("b2b_gap2", 32'(longint'($time) - tp), 10);
        send(4'd7, 1'b0, 32'h80000000, 32'd31);
        check("b2b_srl", result, 32'h1);
        check("b2b_valid", 32'(out_valid), 1);

        send(4'd15, 1'b0, 32'h1234, 32'h5678);
        check("illegal_flag", 32'(illegal), 1);
        check("illegal_result", result, 0);

        send(4'd9, 1'b0, 32'h1234, 32'h5678);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_result", result, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 0);

        for (int i = 0; i < 800; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            in_valid  = $urandom_range(0, 3) != 0;
            op        = 4'($urandom_range(0, 15));
            branch    = $urandom_range(0, 3) == 0;
            a         = pick();
            b         = $urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 40)) : pick();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("drain", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the core single-cycle ALU for the KGP-RISC execute stage. Registers every result behind a valid/ready interface and keeps a persistent carry flag so multi-word adds can chain. Adds add-with-carry, signed overflow, saturating shifts, and an iterative shift-add multiplier. The multiplier is the only multi-cycle operation. Sits between the register-file read stage and writeback; the control unit stalls on `in_ready` low.

## Interface
- `WIDTH`, default 32: operand and result width. Must be at least 4.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Low means reset.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: block accepts an operation this cycle.
- `op` input 4: operation code, see Operation.
- `branch` input 1: when high with ADD, pass `b` through and do not update carry.
- `a` input WIDTH: operand A, signed.
- `b` input WIDTH: operand B, signed; also the shift amount.
- `out_valid` output 1: result held and valid.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: registered result.
- `zero` output 1: `result == 0`.
- `neg` output 1: `result[WIDTH-1]`.
- `ovf` output 1: signed overflow of the last ADD/ADDC result; 0 for all other ops.
- `cout` output 1: persistent carry flag.
- `illegal` output 1: the held result came from an undefined op.

## Operation
- Accept when `in_valid && in_ready`.
- `in_ready` = (state IDLE) or (state DONE and `out_ready`). This gives one op per cycle for single-cycle ops.
- Op codes:
  - 0000 ADD: `a+b`. If `branch`, the result is `b`.
  - 0001 NEG: `~b+1`.
  - 0010 AND.
  - 0011 XOR.
  - 0100 SRA.
  - 0101 SLL.
  - 0110 SRA.
  - 0111 SRL.
  - 1000 ADDC: `a+b+cout`.
  - 1001 MUL: low WIDTH bits of `a*b`.
  - 1010 MULH: high WIDTH bits of the signed 2·WIDTH product.
  - All other codes: result 0, `illegal`=1.
- Shift amount is `b` treated as unsigned, full width.
  - Amount ≥ WIDTH: SLL/SRL give 0; SRA gives all bits = `a[WIDTH-1]`.
- Adds are computed at WIDTH+1 bits. Bit WIDTH is the carry.
  - `ovf` = operand signs equal and result sign differs.
- `cout` updates only when an ADD with `branch`=0, or an ADDC, is accepted. The new value is written on the acceptance edge, so the next accepted op already sees it. All other ops leave `cout` unchanged.
- FSM states IDLE, BUSY, DONE:
  - IDLE, or DONE with `out_ready`, plus accept of a single-cycle op: DONE, with result, flags and `out_valid` loaded.
  - IDLE, or DONE with `out_ready`, plus accept of MUL/MULH: BUSY. Load multiplicand and multiplier magnitudes, clear the 2·WIDTH accumulator, set the counter to WIDTH, drop `out_valid`.
  - BUSY: each cycle, if the multiplier LSB is 1, add the multiplicand into the accumulator upper half; then shift right one bit and decrement the counter. When the counter reaches 0, apply the sign correction (negate if `a[WIDTH-1]^b[WIDTH-1]`) and go to DONE.
  - DONE with `out_ready` and no new accept: IDLE; `out_valid` drops.
  - DONE without `out_ready`: hold all outputs stable.
- `zero` and `neg` are registered with `result` and reflect the result, not the operand.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state IDLE
  - `out_valid`=0
  - `result`=0
  - `zero`=0, `neg`=0, `ovf`=0, `cout`=0, `illegal`=0
  - `in_ready`=1 from the first edge after deassert
- Reset asserted during BUSY aborts the multiply. No result is ever presented.
- Single-cycle op latency: accept on edge N, `out_valid` high after edge N.
- MUL/MULH latency: accept on edge N, `out_valid` high after edge N+WIDTH+1. `in_ready`=0 throughout BUSY.
- Back-to-back: in DONE with `out_ready`=1 and a new accept, the old result is consumed and the new one loads on the same edge. `out_valid` stays high.
- Inputs are sampled only at accept. Changes during BUSY or DONE have no effect.
- `out_valid` never drops without `out_ready` high.

## Test plan
All scenarios use WIDTH=32.
- Reset then ADD `a`=0xFFFFFFFF, `b`=1 -> one cycle later `result`=0, `zero`=1, `cout`=1, `ovf`=0. Next ADDC `a`=0, `b`=0 -> `result`=1, `cout`=0.
- ADD `a`=0x7FFFFFFF, `b`=1 -> `result`=0x80000000, `neg`=1, `ovf`=1. ADD with `branch`=1, `b`=0x1234 -> `result`=0x1234, `cout` unchanged.
- Shifts with `a`=0x80000001:
  - SLL `b`=4 -> 0x00000010
  - SRA `b`=4 -> 0xF8000000
  - SRL `b`=40 -> 0
  - SRA `b`=40 -> 0xFFFFFFFF
- MUL `a`=-3, `b`=7 -> `result`=0xFFFFFFEB exactly 33 cycles after accept, `in_ready`=0 during BUSY. MULH `a`=0x80000000, `b`=2 -> 0xFFFFFFFF.
- Backpressure: hold `out_ready`=0 for 5 cycles after an XOR result -> `result` and flags stable, `in_ready`=0. Then 4 back-to-back ops with `out_ready`=1 -> one result per cycle, in order.
- Illegal `op`=1111 -> `illegal`=1, `result`=0. Drive `rst` low mid-MUL -> `out_valid`=0 immediately, and no result appears after release.
